tx_frame_pacer: RTL and testbench

//  Transmit-side pacing stage that sits directly upstream of the nibble serializer (buffer).

---
 rtl/tx_frame_pacer.sv | 127 ++++++++++++
 tb/tb_tx_frame_pacer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tx_frame_pacer: FIFO-buffered pacer issuing words to the nibble serializer |
// | one write pulse at a time, at least SLOT_CYCLES apart.        Rev 1.0      |
// +----------------------------------------------------------------------------+
module tx_frame_pacer #(
    parameter int WIDTH       = 24,
    parameter int DEPTH       = 4,
    parameter int SLOT_CYCLES = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     write,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] C_GAP_LOAD = GAP_W'(SLOT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [WIDTH-1:0]   r_out_data;
    logic               r_write;
    logic               w_write_nxt;
    logic               w_push;
    logic               w_pop;

    // Full blocks pushes even when a pop lands in the same cycle.
    assign in_ready = reset && (r_count < C_DEPTH);
    assign w_push   = in_valid && in_ready;

    assign out_data = r_out_data;
    assign write    = r_write;
    assign count    = r_count;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_pop       = 1'b0;
        w_write_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_ISSUE;
                    w_pop       = 1'b1;
                    w_write_nxt = 1'b1;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_GAP;
                w_gap_nxt   = C_GAP_LOAD;
            end
            S_GAP: begin
                if (r_gap != '0) begin
                    w_gap_nxt = r_gap - 1'b1;
                end else if (r_count != '0) begin
                    w_state_nxt = S_ISSUE;
                    w_pop       = 1'b1;
                    w_write_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_gap      <= '0;
            r_write    <= 1'b0;
            r_out_data <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= w_gap_nxt;
            r_write <= w_write_nxt;
            if (w_pop) begin
                r_out_data <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the count and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tx_frame_pacer: directed self-checking bench for tx_frame_pacer.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_tx_frame_pacer;

    typedef struct {
        int          cyc;
        logic [23:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [23:0] in_data1 = '0;
    logic        in_valid1 = 1'b0;
    logic        in_ready1;
    logic [23:0] out_data1;
    logic        write1;
    logic [2:0]  count1;
    logic        busy1;

    logic [23:0] in_data2 = '0;
    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [23:0] out_data2;
    logic        write2;
    logic [2:0]  count2;
    logic        busy2;

    ev_t q1[$];
    ev_t q2[$];

    tx_frame_pacer #(.WIDTH(24), .DEPTH(4), .SLOT_CYCLES(6)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
        .out_data(out_data1), .write(write1), .count(count1), .busy(busy1)
    );

    tx_frame_pacer #(.WIDTH(24), .DEPTH(4), .SLOT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .write(write2), .count(count2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write pulses are logged on the falling edge, tagged with the current cycle.
    always @(negedge clk) begin
        if (write1 === 1'b1) q1.push_back('{cyc: cyc, d: out_data1});
        if (write2 === 1'b1) q2.push_back('{cyc: cyc, d: out_data2});
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // Presents a word and holds it until the handshake completes (bounded).
    task automatic offer(input int sel, input logic [23:0] w);
        logic acc;
        acc = 1'b0;
        if (sel == 0) begin in_data1 = w; in_valid1 = 1'b1; end
        else          begin in_data2 = w; in_valid2 = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            acc = (sel == 0) ? in_ready1 : in_ready2;
            tick();
            if (acc) break;
        end
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        chk_eq("offer_accepted", {31'd0, acc}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int m;
        logic [23:0] w5 [3];
        w5[0] = 24'hA00001; w5[1] = 24'hA00002; w5[2] = 24'hA00003;

        // Power-on reset
        reset = 1'b0;
        tick();
        tick();
        chk_eq("rst_write", {31'd0, write1}, 32'd0);
        chk_eq("rst_out_data", {8'd0, out_data1}, 32'd0);
        chk_eq("rst_count", {29'd0, count1}, 32'd0);
        chk_eq("rst_busy", {31'd0, busy1}, 32'd0);
        chk_eq("rst_in_ready", {31'd0, in_ready1}, 32'd0);
        reset = 1'b1;
        tick();
        chk_eq("rel_in_ready", {31'd0, in_ready1}, 32'd1);

        // Single word: write in k+2, idle from k+2+SLOT
        q1.delete();
        k = cyc;
        offer(0, 24'hB98EA1);
        wait_until(k + 5);
        chk_eq("t2_out_held", {8'd0, out_data1}, 32'hB98EA1);
        chk_eq("t2_write_low", {31'd0, write1}, 32'd0);
        wait_until(k + 7);
        chk_eq("t2_busy_k7", {31'd0, busy1}, 32'd1);
        tick();
        chk_eq("t2_busy_k8", {31'd0, busy1}, 32'd0);
        chk_eq("t2_nwr", q1.size(), 32'd1);
        if (q1.size() >= 1) begin
            chk_eq("t2_wr_cyc", q1[0].cyc, k + 2);
            chk_eq("t2_wr_data", {8'd0, q1[0].d}, 32'hB98EA1);
        end

        // Five words back-to-back, then a sixth held while full across a pop
        q1.delete();
        k = cyc;
        for (int i = 1; i <= 5; i++) offer(0, 24'(i));
        chk_eq("t3_cyc_after_offers", cyc, k + 5);
        chk_eq("t3_count_full", {29'd0, count1}, 32'd4);
        chk_eq("t3_ready_full", {31'd0, in_ready1}, 32'd0);
        in_data1  = 24'h000006;
        in_valid1 = 1'b1;
        tick();
        chk_eq("t4_ready_k6", {31'd0, in_ready1}, 32'd0);
        tick();
        chk_eq("t4_count_k7", {29'd0, count1}, 32'd4);
        chk_eq("t4_ready_k7_pop", {31'd0, in_ready1}, 32'd0);
        tick();
        chk_eq("t4_count_k8", {29'd0, count1}, 32'd3);
        chk_eq("t4_ready_k8", {31'd0, in_ready1}, 32'd1);
        tick();
        in_valid1 = 1'b0;
        chk_eq("t4_count_k9", {29'd0, count1}, 32'd4);
        wait_until(k + 40);
        chk_eq("t3_nwr", q1.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < q1.size()) begin
                chk_eq($sformatf("t3_wr%0d_cyc", i), q1[i].cyc, k + 2 + 6 * i);
                chk_eq($sformatf("t3_wr%0d_data", i), {8'd0, q1[i].d}, i + 1);
            end
        end
        chk_eq("t3_idle_busy", {31'd0, busy1}, 32'd0);

        // Reset asserted during GAP with words still queued
        q1.delete();
        k = cyc;
        for (int i = 0; i < 3; i++) offer(0, w5[i]);
        tick();
        reset = 1'b0;
        #1;
        chk_eq("t5_ready_in_rst", {31'd0, in_ready1}, 32'd0);
        tick();
        tick();
        chk_eq("t5_write", {31'd0, write1}, 32'd0);
        chk_eq("t5_out_data", {8'd0, out_data1}, 32'd0);
        chk_eq("t5_count", {29'd0, count1}, 32'd0);
        chk_eq("t5_busy", {31'd0, busy1}, 32'd0);
        chk_eq("t5_ready_rst", {31'd0, in_ready1}, 32'd0);
        reset = 1'b1;
        tick();
        chk_eq("t5_ready_rel", {31'd0, in_ready1}, 32'd1);
        wait_until(k + 30);
        chk_eq("t5_nwr", q1.size(), 32'd1);
        if (q1.size() >= 1) begin
            chk_eq("t5_wr_cyc", q1[0].cyc, k + 2);
            chk_eq("t5_wr_data", {8'd0, q1[0].d}, 32'hA00001);
        end
        q1.delete();
        m = cyc;
        offer(0, 24'hC0FFEE);
        wait_until(m + 10);
        chk_eq("t5_new_nwr", q1.size(), 32'd1);
        if (q1.size() >= 1) begin
            chk_eq("t5_new_cyc", q1[0].cyc, m + 2);
            chk_eq("t5_new_data", {8'd0, q1[0].d}, 32'hC0FFEE);
        end

        // SLOT_CYCLES=2: writes every other cycle
        q2.delete();
        k = cyc;
        offer(1, 24'h5A0001);
        offer(1, 24'h5A0002);
        offer(1, 24'h5A0003);
        offer(1, 24'h5A0004);
        wait_until(k + 14);
        chk_eq("t6_nwr", q2.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q2.size()) begin
                chk_eq($sformatf("t6_wr%0d_cyc", i), q2[i].cyc, k + 2 + 2 * i);
                chk_eq($sformatf("t6_wr%0d_data", i), {8'd0, q2[i].d}, 32'h5A0001 + i);
            end
        end
        chk_eq("t6_count_end", {29'd0, count2}, 32'd0);
        chk_eq("t6_busy_end", {31'd0, busy2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
